pc_fetch_unit: RTL and testbench

- Owns the architectural program counter and produces the byte-addressed instruction fetch address. The instruction memory's word-index extractor consumes this address downstream.
- Each cycle it selects the next PC from four sources: sequential, branch, jump or register jump.
- It checks the result for word alignment and instruction-memory range. On a violation it halts, holding the last good PC until reset.

---
 rtl/pc_fetch_unit_pkg.sv | 26 ++
 rtl/pc_fetch_unit_npc_calc.sv | 58 +++++
 rtl/pc_fetch_unit.sv | 81 ++++++++
 tb/tb_pc_fetch_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings and default memory map for the PC fetch unit.
package pc_fetch_unit_pkg;

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam int unsigned DEFAULT_IM_WORDS = 32'd4096;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Word-aligned byte addresses have zero in the two low bits.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_npc_calc.sv
// Combinational next-PC candidate selection plus alignment/range classification.
module pc_fetch_unit_npc_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned IM_WORDS = DEFAULT_IM_WORDS
) (
  input  logic [31:0] pc,
  input  logic [1:0]  npc_sel,
  input  logic        cmp_true,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_val,
  output logic [31:0] npc,
  output logic [1:0]  fault_code
);

  // Upper bound kept at 33 bits so a memory ending at 2^32 cannot wrap.
  localparam logic [31:0] IM_BYTES = 32'(IM_WORDS) << 2;
  localparam logic [32:0] IM_END   = {1'b0, RESET_PC} + {1'b0, IM_BYTES};

  logic [31:0] seq_s;
  logic [31:0] br_off_s;

  assign seq_s    = pc + 32'd4;
  assign br_off_s = {{14{imm16[15]}}, imm16, 2'b00};

  // Candidate mux over the four next-PC sources.
  always_comb begin
    npc = seq_s;
    case (npc_sel)
      NPC_SEQ:    npc = seq_s;
      NPC_BRANCH: begin
        if (cmp_true) begin
          npc = seq_s + br_off_s;
        end else begin
          npc = seq_s;
        end
      end
      NPC_JUMP:   npc = {pc[31:28], imm26, 2'b00};
      NPC_JR:     npc = rs_val;
      default:    npc = seq_s;
    endcase
  end

  // Misalignment outranks the range check when both apply.
  always_comb begin
    fault_code = FAULT_NONE;
    if (is_misaligned(npc)) begin
      fault_code = FAULT_MISALIGN;
    end else if ((npc < RESET_PC) || ({1'b0, npc} >= IM_END)) begin
      fault_code = FAULT_RANGE;
    end else begin
      fault_code = FAULT_NONE;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC register with RUN/HALT control and a sticky fault code.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned IM_WORDS = DEFAULT_IM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        cmp_true,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_val,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic [1:0]  fault
);

  state_e      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [1:0]  fault_r, fault_s;
  logic [31:0] npc_s;
  logic [1:0]  npc_fault_s;

  pc_fetch_unit_npc_calc #(
    .RESET_PC (RESET_PC),
    .IM_WORDS (IM_WORDS)
  ) u_npc_calc (
    .pc         (pc_r),
    .npc_sel    (npc_sel),
    .cmp_true   (cmp_true),
    .imm16      (imm16),
    .imm26      (imm26),
    .rs_val     (rs_val),
    .npc        (npc_s),
    .fault_code (npc_fault_s)
  );

  // State, PC and fault registers; only reset leaves HALT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
      pc_r    <= RESET_PC;
      fault_r <= FAULT_NONE;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      fault_r <= fault_s;
    end
  end

  // Next-state logic: an illegal candidate never reaches pc_r.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    fault_s = fault_r;
    case (state_r)
      ST_RUN: begin
        if (stall) begin
          pc_s = pc_r;
        end else if (npc_fault_s != FAULT_NONE) begin
          state_s = ST_HALT;
          fault_s = npc_fault_s;
        end else begin
          pc_s = npc_s;
        end
      end
      ST_HALT: state_s = ST_HALT;
      default: state_s = ST_HALT;
    endcase
  end

  assign pc       = pc_r;
  assign pc_plus4 = pc_r + 32'd4;
  assign halted   = (state_r == ST_HALT);
  assign fault    = fault_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit using immediate assertions.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic        cmp_true = 1'b0;
  logic [15:0] imm16 = 16'h0000;
  logic [25:0] imm26 = 26'h0;
  logic [31:0] rs_val = 32'h0;
  logic [31:0] pc, pc_plus4;
  logic        halted;
  logic [1:0]  fault;

  int vectors = 0;
  int miscompares = 0;

  pc_fetch_unit dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .npc_sel  (npc_sel),
    .cmp_true (cmp_true),
    .imm16    (imm16),
    .imm26    (imm26),
    .rs_val   (rs_val),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .halted   (halted),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full architectural snapshot against expectations.
  task automatic check_all(input string tag, input logic [31:0] epc,
                           input logic ehalt, input logic [1:0] efault);
    check({tag, ".pc"}, pc, epc);
    check({tag, ".pc_plus4"}, pc_plus4, epc + 32'd4);
    check({tag, ".halted"}, {31'd0, halted}, {31'd0, ehalt});
    check({tag, ".fault"}, {30'd0, fault}, {30'd0, efault});
  endtask

  // One clock edge, sampled 1ns later, with the legal-PC invariant checked.
  task automatic tick();
    @(posedge clk);
    #1;
    check("pc_legal", {31'd0, (pc[1:0] == 2'b00) && (pc >= 32'h3000) && (pc < 32'h7000)}, 32'd1);
  endtask

  task automatic drive(input logic [1:0] sel, input logic ct, input logic [15:0] i16,
                       input logic [25:0] i26, input logic [31:0] rs);
    npc_sel  = sel;
    cmp_true = ct;
    imm16    = i16;
    imm26    = i26;
    rs_val   = rs;
  endtask

  // Async reset pulse placed away from any clock edge.
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_all("async_rst", 32'h3000, 1'b0, 2'b00);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Reset asserted mid-cycle, checked before any clock edge.
    #2;
    reset = 1'b0;
    #1;
    check_all("reset", 32'h3000, 1'b0, 2'b00);
    @(negedge clk);
    reset = 1'b1;

    drive(2'b00, 1'b0, 16'h0000, 26'h0, 32'h0);
    tick(); check("seq1", pc, 32'h3004);
    tick(); check("seq2", pc, 32'h3008);
    tick(); check_all("seq3", 32'h300C, 1'b0, 2'b00);

    drive(2'b11, 1'b0, 16'h0000, 26'h0, 32'h3008);
    tick(); check("jr_3008", pc, 32'h3008);
    drive(2'b01, 1'b1, 16'hFFFF, 26'h0, 32'h0);
    tick(); check("br_back", pc, 32'h3008);
    drive(2'b01, 1'b0, 16'hFFFF, 26'h0, 32'h0);
    tick(); check("br_nt", pc, 32'h300C);
    drive(2'b11, 1'b0, 16'h0000, 26'h0, 32'h3000);
    tick(); check("jr_3000", pc, 32'h3000);
    drive(2'b01, 1'b1, 16'h0003, 26'h0, 32'h0);
    tick(); check("br_fwd", pc, 32'h3010);

    drive(2'b11, 1'b0, 16'h0000, 26'h0, 32'h3000);
    tick();
    drive(2'b10, 1'b0, 16'h0000, 26'h0000C05, 32'h0);
    tick(); check("jump", pc, 32'h0000_3014);
    drive(2'b11, 1'b0, 16'h0000, 26'h0, 32'h3100);
    tick(); check("jr_3100", pc, 32'h3100);

    // Illegal target under stall is not checked.
    stall = 1'b1;
    drive(2'b11, 1'b0, 16'h0000, 26'h0, 32'h3002);
    tick(); check_all("stall_illegal", 32'h3100, 1'b0, 2'b00);
    tick(); check_all("stall_hold2", 32'h3100, 1'b0, 2'b00);
    stall = 1'b0;
    tick(); check_all("misalign_halt", 32'h3100, 1'b1, 2'b01);

    pulse_reset();
    drive(2'b11, 1'b0, 16'h0000, 26'h0, 32'h6FFC);
    tick(); check_all("last_word", 32'h6FFC, 1'b0, 2'b00);
    drive(2'b00, 1'b0, 16'h0000, 26'h0, 32'h0);
    tick(); check_all("seq_off_end", 32'h6FFC, 1'b1, 2'b10);
    drive(2'b10, 1'b0, 16'h0000, 26'h0000C05, 32'h0);
    tick(); check_all("halt_jump", 32'h6FFC, 1'b1, 2'b10);
    drive(2'b11, 1'b0, 16'h0000, 26'h0, 32'h3100);
    tick(); check_all("halt_jr", 32'h6FFC, 1'b1, 2'b10);
    pulse_reset();

    drive(2'b11, 1'b0, 16'h0000, 26'h0, 32'h0000_0001);
    tick(); check_all("both_bad", 32'h3000, 1'b1, 2'b01);
    pulse_reset();

    drive(2'b01, 1'b1, 16'h8000, 26'h0, 32'h0);
    tick(); check_all("br_wrap", 32'h3000, 1'b1, 2'b10);
    pulse_reset();

    drive(2'b11, 1'b0, 16'h0000, 26'h0, 32'h2FFC);
    tick(); check_all("below_base", 32'h3000, 1'b1, 2'b10);
    pulse_reset();

    drive(2'b11, 1'b0, 16'h0000, 26'h0, 32'h7000);
    tick(); check_all("at_limit", 32'h3000, 1'b1, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
